vproc_result_writer: RTL and testbench
======================================

Name: vproc_result_writer

Overview:
- Store-side counterpart of the operand fetch path.
- Accepts PIPE_W-wide result beats from an execution unit, each tagged with store info (vreg, shift).
- Assembles beats into full VREG_W register words and drives the vector register file write port.
- Clears the destination's pending-write hazard bit on the final write of an instruction.

Parameters:
- VREG_W, 128, vector register width in bits.
- PIPE_W, 32, result beat width in bits. VREG_W/PIPE_W must be a power of two, at least 1.
- BEATS, VREG_W/PIPE_W (derived, localparam), beats per register word.

Ports:
- clk_i  in  1  clock
- sync_rst_i  in  1  synchronous active-high reset
- res_valid_i  in  1  result beat valid
- res_ready_o  out  1  writer can accept a beat
- res_data_i  in  PIPE_W  result data
- res_mask_i  in  PIPE_W/8  per-byte write enable of this beat
- res_old_i  in  PIPE_W  old vd content for this beat (merge source)
- res_store_vreg_i  in  1  beat completes a register word (store_info.vreg)
- res_store_shift_i  in  1  beat is shifted into the buffer (store_info.shift)
- res_last_i  in  1  beat belongs to the last register word of the instruction
- res_vd_i  in  5  destination base address
- vreg_wr_en_o  out  1  register file write strobe
- vreg_wr_addr_o  out  5  write address
- vreg_wr_data_o  out  VREG_W  write data
- vreg_wr_be_o  out  VREG_W/8  byte enables
- clear_hazard_o  out  32  one-hot pending-write clear for vd group

Behaviour:
- All state is updated on the rising edge of clk_i.
- Reset values:
  - State FILL.
  - Buffer 0, mask buffer 0.
  - Beat counter 0, register index (emul counter) 0.
  - res_ready_o 1.
  - vreg_wr_en_o 0, vreg_wr_addr_o 0, vreg_wr_data_o 0, vreg_wr_be_o 0.
  - clear_hazard_o 0.
- Handshake: a beat is accepted when res_valid_i && res_ready_o. res_ready_o = (state==FILL), a registered output.
- FILL, accepted beat with shift=1:
  - buffer <= {beat, buffer[VREG_W-1:PIPE_W]} (LSB-first; the first beat lands at bits [PIPE_W-1:0] after BEATS shifts).
  - The mask buffer shifts the same way.
  - The beat counter increments and wraps modulo BEATS.
- Accepted beat with shift=0: the buffer is unchanged, and the beat still counts toward vreg/last handling.
- Accepted beat with vreg=1: go to COMMIT and latch addr = res_vd_i | {2'b00, emul_idx[2:0]} and last = res_last_i.
  - vreg=1 with fewer than BEATS shifts is legal. The buffer is written as-is and the beat counter resets to 0.
- COMMIT (exactly one cycle):
  - vreg_wr_en_o=1, with data/be/addr from the buffer and latch.
  - If last: clear_hazard_o[addr]=1 for that cycle, and emul_idx <= 0. Otherwise emul_idx increments.
  - Return to FILL with res_ready_o=1 the next cycle. Throughput is BEATS+1 cycles per register.
- Write latency: the write strobe appears one cycle after the accepting edge of the vreg=1 beat.
- Outputs other than vreg_wr_addr_o/vreg_wr_data_o are 0 outside COMMIT. Those two hold their last value.
- emul_idx wraps at 8 (LMUL 8 maximum). The 9th non-last write of one instruction is undefined usage; emul_idx simply wraps.
- Reset asserted during COMMIT: no write strobe on the following cycle, and all state returns to reset values.
- res_valid_i in COMMIT is ignored (not accepted). The beat must be held until ready.

Optional Feature:
- Macro: VPROC_RESULT_BYTE_MASK_EN.
- Defined:
  - vreg_wr_be_o = mask buffer.
  - res_old_i is ignored.
  - The register file performs the masked write.
- Undefined:
  - Each beat is merged before buffering: byte b = res_mask_i[b] ? res_data_i byte : res_old_i byte.
  - vreg_wr_be_o is all-ones in COMMIT.

Test Plan:
- Full word, 4 beats of 0x11111111, 0x22222222, 0x33333333, 0x44444444 with shift=1, 4th beat vreg=1, last=1, vd=8 -> one cycle later wr_en=1, addr=8, data=0x44444444_33333333_22222222_11111111, clear_hazard_o=1<<8.
- LMUL 2, vd=4, two words with the second last -> writes to addr 4 then 5. clear_hazard only with the second write. emul_idx is 0 afterwards.
- Backpressure: valid held high through COMMIT -> res_ready_o=0 that cycle. The beat is accepted the next cycle and no beat is lost or duplicated.
- Mask 0b0101 on beat 0xAABBCCDD with old 0x11223344:
  - With macro: be nibble 0101, data 0xAABBCCDD.
  - Without macro: data 0x11BB33DD, be all-ones.
- Reset asserted on the COMMIT cycle -> no wr_en the next cycle. res_ready_o=1, buffer 0, and a subsequent 4-beat word is written correctly.
- Early commit: 2 shift beats, the second with vreg=1 -> written data holds the beats in the upper half, and the beat counter returns to 0.

Source files
------------

// File: rtl/vproc_result_writer.sv
// Vector result writer: assembles PIPE_W result beats into VREG_W register words and
// drives the vector register file write port, clearing the pending-write hazard bit on
// the final write of an instruction.
//
// Build option VPROC_RESULT_BYTE_MASK_EN:
//   defined   - per-byte masks are buffered and forwarded as write byte enables; the
//               register file performs the masked write and res_old_i is ignored.
//   undefined - each beat is merged with res_old_i under its byte mask before buffering
//               and the write byte enables are all-ones.
module vproc_result_writer #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned PIPE_W = 32
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic [PIPE_W-1:0]     res_data_i,
  input  logic [PIPE_W/8-1:0]   res_mask_i,
  input  logic [PIPE_W-1:0]     res_old_i,
  input  logic                  res_store_vreg_i,
  input  logic                  res_store_shift_i,
  input  logic                  res_last_i,
  input  logic [4:0]            res_vd_i,
  output logic                  vreg_wr_en_o,
  output logic [4:0]            vreg_wr_addr_o,
  output logic [VREG_W-1:0]     vreg_wr_data_o,
  output logic [VREG_W/8-1:0]   vreg_wr_be_o,
  output logic [31:0]           clear_hazard_o
);

  localparam int unsigned BEATS = VREG_W / PIPE_W;
  localparam int unsigned PipeB = PIPE_W / 8;
  localparam int unsigned VregB = VREG_W / 8;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BEATS - 1);

  typedef enum logic [0:0] {StFill, StCommit} state_e;

  state_e              state_q;
  logic [VREG_W-1:0]   buf_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          emul_q;
  logic                last_q;
  logic                ready_q;
  logic                wr_en_q;
  logic [4:0]          wr_addr_q;
  logic [VREG_W-1:0]   wr_data_q;
  logic [VregB-1:0]    wr_be_q;
  logic [31:0]         clr_q;

  logic [PIPE_W-1:0]   beat;
  logic [VREG_W-1:0]   buf_shift;
  logic [VREG_W-1:0]   buf_d;
  logic [VregB-1:0]    be_d;
  logic [4:0]          addr_d;
  logic [31:0]         clr_d;
  logic                accept;

  assign accept = res_valid_i && ready_q;

`ifdef VPROC_RESULT_BYTE_MASK_EN
  logic [VregB-1:0] mask_q;
  logic [VregB-1:0] mask_shift;
  logic [VregB-1:0] mask_d;
  logic             unused_old;

  // Old content is not needed: the register file applies the byte enables itself.
  assign unused_old = ^res_old_i;
  assign beat       = res_data_i;

  if (BEATS > 1) begin : g_mask_shift
    logic unused_mask_lsb;
    assign unused_mask_lsb = ^mask_q[PipeB-1:0];
    assign mask_shift      = {res_mask_i, mask_q[VregB-1:PipeB]};
  end else begin : g_mask_single
    logic unused_mask;
    assign unused_mask = ^mask_q;
    assign mask_shift  = res_mask_i;
  end

  assign mask_d = res_store_shift_i ? mask_shift : mask_q;
  assign be_d   = mask_d;

  // Mask buffer follows the data buffer beat for beat.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      mask_q <= '0;
    end else if (accept && (state_q == StFill) && res_store_shift_i) begin
      mask_q <= mask_shift;
    end
  end
`else
  // Merge each byte with the old destination content before it enters the buffer.
  always_comb begin
    beat = res_data_i;
    for (int b = 0; b < int'(PipeB); b++) begin
      if (!res_mask_i[b]) begin
        beat[8*b +: 8] = res_old_i[8*b +: 8];
      end
    end
  end

  assign be_d = {VregB{1'b1}};
`endif

  // LSB-first shift: the newest beat enters at the top, the oldest drops out the bottom.
  if (BEATS > 1) begin : g_buf_shift
    logic unused_buf_lsb;
    assign unused_buf_lsb = ^buf_q[PIPE_W-1:0];
    assign buf_shift      = {beat, buf_q[VREG_W-1:PIPE_W]};
  end else begin : g_buf_single
    logic unused_buf;
    assign unused_buf = ^buf_q;
    assign buf_shift  = beat;
  end

  // Word to be written, destination address and hazard clear for a completing beat.
  always_comb begin
    buf_d  = res_store_shift_i ? buf_shift : buf_q;
    addr_d = res_vd_i | {2'b00, emul_q};
    clr_d  = '0;
    if (res_last_i) begin
      clr_d = 32'd1 << addr_d;
    end
  end

  // Fill/commit FSM with registered handshake and write-port outputs.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q   <= StFill;
      buf_q     <= '0;
      cnt_q     <= '0;
      emul_q    <= '0;
      last_q    <= 1'b0;
      ready_q   <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      clr_q     <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (res_store_shift_i) begin
              buf_q <= buf_shift;
              cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
            end
            if (res_store_vreg_i) begin
              // An early vreg writes whatever the buffer holds and restarts the count.
              state_q   <= StCommit;
              cnt_q     <= '0;
              last_q    <= res_last_i;
              ready_q   <= 1'b0;
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_d;
              wr_data_q <= buf_d;
              wr_be_q   <= be_d;
              clr_q     <= clr_d;
            end
          end
        end
        StCommit: begin
          state_q <= StFill;
          ready_q <= 1'b1;
          wr_en_q <= 1'b0;
          wr_be_q <= '0;
          clr_q   <= '0;
          // Register index wraps at 8 (LMUL 8 maximum) and restarts on the last word.
          emul_q  <= last_q ? 3'd0 : emul_q + 3'd1;
        end
        default: begin
          state_q <= StFill;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign res_ready_o    = ready_q;
  assign vreg_wr_en_o   = wr_en_q;
  assign vreg_wr_addr_o = wr_addr_q;
  assign vreg_wr_data_o = wr_data_q;
  assign vreg_wr_be_o   = wr_be_q;
  assign clear_hazard_o = clr_q;

endmodule

// File: tb/tb_vproc_result_writer.sv
// Bench for vproc_result_writer: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a beat-array reference model.
module tb_vproc_result_writer;

  localparam int unsigned VREG_W = 128;
  localparam int unsigned PIPE_W = 32;
  localparam int unsigned BEATS  = VREG_W / PIPE_W;
  localparam int unsigned PB     = PIPE_W / 8;
  localparam int unsigned VB     = VREG_W / 8;

  logic              clk;
  logic              sync_rst;
  logic              res_valid;
  logic              res_ready;
  logic [PIPE_W-1:0] res_data;
  logic [PB-1:0]     res_mask;
  logic [PIPE_W-1:0] res_old;
  logic              res_vreg;
  logic              res_shift;
  logic              res_last;
  logic [4:0]        res_vd;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [VREG_W-1:0] wr_data;
  logic [VB-1:0]     wr_be;
  logic [31:0]       clr;

  vproc_result_writer #(
    .VREG_W (VREG_W),
    .PIPE_W (PIPE_W)
  ) dut (
    .clk_i             (clk),
    .sync_rst_i        (sync_rst),
    .res_valid_i       (res_valid),
    .res_ready_o       (res_ready),
    .res_data_i        (res_data),
    .res_mask_i        (res_mask),
    .res_old_i         (res_old),
    .res_store_vreg_i  (res_vreg),
    .res_store_shift_i (res_shift),
    .res_last_i        (res_last),
    .res_vd_i          (res_vd),
    .vreg_wr_en_o      (wr_en),
    .vreg_wr_addr_o    (wr_addr),
    .vreg_wr_data_o    (wr_data),
    .vreg_wr_be_o      (wr_be),
    .clear_hazard_o    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the buffered word as an array of beats, index 0 = least significant.
  logic [PIPE_W-1:0] m_beat [BEATS];
  logic [PB-1:0]     m_mask [BEATS];
  int                m_emul;
  bit                m_last;
  bit                m_in_commit;
  logic              exp_ready;
  logic              exp_en;
  logic [4:0]        exp_addr;
  logic [VREG_W-1:0] exp_data;
  logic [VB-1:0]     exp_be;
  logic [31:0]       exp_clr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(BEATS); i++) begin
      m_beat[i] = '0;
      m_mask[i] = '0;
    end
    m_emul      = 0;
    m_last      = 0;
    m_in_commit = 0;
    exp_ready   = 1'b1;
    exp_en      = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
    exp_be      = '0;
    exp_clr     = '0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_update();
    logic [PIPE_W-1:0] nb;
    if (sync_rst) begin
      model_reset();
    end else if (m_in_commit) begin
      m_emul      = m_last ? 0 : (m_emul + 1) % 8;
      m_in_commit = 0;
      exp_ready   = 1'b1;
      exp_en      = 1'b0;
      exp_be      = '0;
      exp_clr     = '0;
    end else if (res_valid && exp_ready) begin
      if (res_shift) begin
        nb = res_data;
`ifndef VPROC_RESULT_BYTE_MASK_EN
        for (int b = 0; b < int'(PB); b++)
          if (!res_mask[b]) nb[8*b +: 8] = res_old[8*b +: 8];
`endif
        for (int i = 0; i < int'(BEATS) - 1; i++) begin
          m_beat[i] = m_beat[i+1];
          m_mask[i] = m_mask[i+1];
        end
        m_beat[BEATS-1] = nb;
        m_mask[BEATS-1] = res_mask;
      end
      if (res_vreg) begin
        m_in_commit = 1;
        m_last      = res_last;
        exp_ready   = 1'b0;
        exp_en      = 1'b1;
        exp_addr    = res_vd | 5'(m_emul);
        for (int i = 0; i < int'(BEATS); i++) begin
          exp_data[PIPE_W*i +: PIPE_W] = m_beat[i];
`ifdef VPROC_RESULT_BYTE_MASK_EN
          exp_be[PB*i +: PB] = m_mask[i];
`endif
        end
`ifndef VPROC_RESULT_BYTE_MASK_EN
        exp_be = '1;
`endif
        exp_clr = res_last ? (32'd1 << exp_addr) : 32'd0;
      end
    end
  endtask

  task automatic compare_all();
    chk("ready", res_ready, exp_ready);
    chk("wr_en", wr_en, exp_en);
    chk("wr_addr", wr_addr, exp_addr);
    chk("wr_data", wr_data, exp_data);
    chk("wr_be", wr_be, exp_be);
    chk("clear_hazard", clr, exp_clr);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then compare.
  task automatic step(input bit rst, input bit v, input logic [31:0] d, input logic [3:0] m,
                      input logic [31:0] o, input bit vr, input bit sh, input bit la,
                      input logic [4:0] vd);
    sync_rst  = rst;
    res_valid = v;
    res_data  = d;
    res_mask  = m;
    res_old   = o;
    res_vreg  = vr;
    res_shift = sh;
    res_last  = la;
    res_vd    = vd;
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic beat(input logic [31:0] d, input bit vr, input bit la, input logic [4:0] vd);
    step(0, 1, d, 4'hf, 32'h0, vr, 1, la, vd);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 5'd0);
  endtask

  task automatic word4(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                       input logic [31:0] b3, input bit la, input logic [4:0] vd);
    beat(b0, 0, 0, vd);
    beat(b1, 0, 0, vd);
    beat(b2, 0, 0, vd);
    beat(b3, 1, la, vd);
  endtask

  int s_cnt;

  initial begin
    bit r, v, sh, vr, la;
    model_reset();
    step(1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 5'd0);
    step(1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 5'd0);
    chk("rst_ready", res_ready, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_data", wr_data, 128'h0);
    chk("rst_clr", clr, 32'h0);

    // Full word, last, vd=8.
    word4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1, 5'd8);
    chk("full_en", wr_en, 1'b1);
    chk("full_addr", wr_addr, 5'd8);
    chk("full_data", wr_data, 128'h44444444_33333333_22222222_11111111);
    chk("full_clr", clr, 32'h0000_0100);
    chk("full_be", wr_be, 16'hffff);
    idle();

    // LMUL 2 at vd=4.
    word4(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 5'd4);
    chk("lmul2_addr0", wr_addr, 5'd4);
    chk("lmul2_clr0", clr, 32'h0);
    idle();
    word4(32'hB0, 32'hB1, 32'hB2, 32'hB3, 1, 5'd4);
    chk("lmul2_addr1", wr_addr, 5'd5);
    chk("lmul2_clr1", clr, 32'h0000_0020);
    idle();
    word4(32'hC0, 32'hC1, 32'hC2, 32'hC3, 1, 5'd12);
    chk("emul_restart_addr", wr_addr, 5'd12);

    // Backpressure: a held beat during COMMIT is taken exactly once afterwards.
    beat(32'hD0, 0, 0, 5'd0);
    beat(32'hD1, 0, 0, 5'd0);
    beat(32'hD2, 0, 0, 5'd0);
    beat(32'hD3, 1, 1, 5'd0);
    chk("bp_ready_low", res_ready, 1'b0);
    beat(32'h5555AAAA, 0, 0, 5'd1);
    chk("bp_ready_back", res_ready, 1'b1);
    beat(32'h5555AAAA, 0, 0, 5'd1);
    beat(32'hE1, 0, 0, 5'd1);
    beat(32'hE2, 0, 0, 5'd1);
    beat(32'hE3, 1, 1, 5'd1);
    chk("bp_data", wr_data, 128'h000000E3_000000E2_000000E1_5555AAAA);
    idle();

    // Byte-mask handling on a single-beat early commit.
    step(0, 1, 32'hAABBCCDD, 4'b0101, 32'h11223344, 1, 1, 1, 5'd2);
`ifdef VPROC_RESULT_BYTE_MASK_EN
    chk("mask_data", wr_data[127:96], 32'hAABBCCDD);
    chk("mask_be", wr_be[15:12], 4'b0101);
`else
    chk("mask_data", wr_data[127:96], 32'h11BB33DD);
    chk("mask_be", wr_be, 16'hffff);
`endif
    idle();

    // Reset on the COMMIT cycle suppresses the write.
    beat(32'hF0, 1, 1, 5'd3);
    step(1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 5'd0);
    chk("rstc_wr_en", wr_en, 1'b0);
    chk("rstc_ready", res_ready, 1'b1);
    // Early commit after reset: two beats in the upper half, zeros below.
    beat(32'hCAFEF00D, 0, 0, 5'd6);
    beat(32'h12345678, 1, 1, 5'd6);
    chk("early_addr", wr_addr, 5'd6);
    chk("early_data", wr_data, 128'h12345678_CAFEF00D_00000000_00000000);
    idle();
    word4(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 1, 5'd9);
    chk("post_rst_data", wr_data, 128'h0D0E0F10_090A0B0C_05060708_01020304);
    chk("post_rst_addr", wr_addr, 5'd9);
    idle();

    // Randomized traffic.
    s_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(299) == 0) || (m_in_commit && $urandom_range(19) == 0);
      v  = $urandom_range(3) != 0;
      sh = $urandom_range(7) != 0;
      if (s_cnt == int'(BEATS) - 1 && sh) vr = $urandom_range(7) != 0;
      else vr = $urandom_range(15) == 0;
      la = $urandom_range(2) == 0;
      if (r) s_cnt = 0;
      else if (v && exp_ready) begin
        if (vr) s_cnt = 0;
        else if (sh) s_cnt = (s_cnt + 1) % int'(BEATS);
      end
      step(r, v, $urandom, 4'($urandom), $urandom, vr, sh, la, 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
